// File: rtl/serial_tx_pkg.sv
//------------------------------------------------------------------------------
// serial_tx_pkg : shared encodings for the 8051 serial port transmit path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_tx_pkg;

  localparam logic [1:0] c_MODE0 = 2'b00;
  localparam logic [1:0] c_MODE1 = 2'b01;
  localparam logic [1:0] c_MODE2 = 2'b10;
  localparam logic [1:0] c_MODE3 = 2'b11;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_NINTH = 3'd3;
  localparam logic [2:0] c_ST_STOP  = 3'd4;

  localparam int c_OVERSAMPLE_DEF = 16;

  // Opcode the core decodes into the SBUF write strobe.
  localparam logic [7:0] c_OP_SBUF_WR_BYTE = 8'hF5;

  typedef enum logic [2:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_START = c_ST_START,
    ST_DATA  = c_ST_DATA,
    ST_NINTH = c_ST_NINTH,
    ST_STOP  = c_ST_STOP
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
//------------------------------------------------------------------------------
// serial_bit_timer : counts baud ticks and flags the last tick of a bit time
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_bit_timer #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_done
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last     = (r_cnt == c_LAST);
  assign o_bit_done = i_tick & w_last & ~i_clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
//------------------------------------------------------------------------------
// serial_tx : 8051 serial port transmitter, asynchronous modes 1, 2 and 3
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int OVERSAMPLE = c_OVERSAMPLE_DEF,
  parameter int CNT_W      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_tb8,
  input  logic [1:0] i_mode,
  input  logic       i_baud_tick,
  output logic       o_txd,
  output logic       o_ti_set,
  output logic       o_busy
);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic       r_tb8;
  logic [1:0] r_mode;
  logic [2:0] r_bit_cnt;

  logic w_idle;
  logic w_accept;
  logic w_bit_done;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & i_start & (i_mode != c_MODE0);

  // Holding the timer clear in IDLE makes the accept edge the start-bit origin.
  serial_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_idle),
    .i_tick     (i_baud_tick),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_tb8     <= 1'b0;
      r_mode    <= c_MODE0;
      r_bit_cnt <= '0;
      o_txd     <= 1'b1;
      o_ti_set  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_ti_set <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_txd  <= 1'b1;
          o_busy <= 1'b0;
          if (w_accept) begin
            r_shift   <= i_byte;
            r_tb8     <= i_tb8;
            r_mode    <= i_mode;
            r_bit_cnt <= '0;
            r_state   <= ST_START;
            o_txd     <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_state <= ST_DATA;
            o_txd   <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              if (r_mode == c_MODE1) begin
                r_state  <= ST_STOP;
                o_txd    <= 1'b1;
                o_ti_set <= 1'b1;
              end else begin
                r_state <= ST_NINTH;
                o_txd   <= r_tb8;
              end
            end else begin
              o_txd <= r_shift[1];
            end
          end
        end
        ST_NINTH: begin
          if (w_bit_done) begin
            r_state  <= ST_STOP;
            o_txd    <= 1'b1;
            o_ti_set <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_txd   <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
//------------------------------------------------------------------------------
// tb_serial_tx : randomized bench for serial_tx against a frame-level model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_tx;

  localparam int OS = 16;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       tb8    = 1'b0;
  logic [1:0] mode   = 2'b00;
  logic       tick   = 1'b0;
  wire        txd;
  wire        ti;
  wire        busy;

  serial_tx #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_byte      (byte_i),
    .i_tb8       (tb8),
    .i_mode      (mode),
    .i_baud_tick (tick),
    .o_txd       (txd),
    .o_ti_set    (ti),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_total  = 0;
  int n_bad    = 0;
  int ti_count = 0;
  int tick_ctr = 0;

  // Frame-level reference: the line level is bits[ticks / OS] of the frame.
  bit m_busy  = 1'b0;
  bit m_txd   = 1'b1;
  bit m_ti    = 1'b0;
  int m_ticks = 0;
  int m_nbits = 0;
  bit m_bits [0:10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit next_tick(input int period);
    bit r;
    r = ((tick_ctr % period) == 0);
    tick_ctr++;
    return r;
  endfunction

  task automatic model_step();
    m_ti = 1'b0;
    if (!m_busy) begin
      if (start && mode != 2'b00) begin
        m_busy    = 1'b1;
        m_ticks   = 0;
        m_nbits   = (mode == 2'b01) ? 10 : 11;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = byte_i[i];
        if (m_nbits == 11) begin
          m_bits[9]  = tb8;
          m_bits[10] = 1'b1;
        end else begin
          m_bits[9] = 1'b1;
        end
      end
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == m_nbits * OS) m_busy = 1'b0;
      else if (m_ticks == (m_nbits - 1) * OS) m_ti = 1'b1;
    end
    m_txd = m_busy ? m_bits[m_ticks / OS] : 1'b1;
  endtask

  task automatic cycle(input bit s, input logic [7:0] b, input bit t8,
                       input logic [1:0] md, input bit tk);
    @(negedge clk);
    start = s; byte_i = b; tb8 = t8; mode = md; tick = tk;
    model_step();
    @(posedge clk);
    #1;
    check("txd",  32'(txd),  32'(m_txd));
    check("busy", 32'(busy), 32'(m_busy));
    check("ti",   32'(ti),   32'(m_ti));
    if (ti) ti_count++;
  endtask

  task automatic idle(input int n, input int period);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 2'($urandom), next_tick(period));
  endtask

  // Runs one frame; optional ignored start at a given tick, random mid-frame
  // noise, or a start on the very clock the frame ends.
  task automatic frame(input logic [7:0] b, input bit t8, input logic [1:0] md,
                       input int period, input bit noise, input int inject,
                       input bit edge_start);
    bit s, tk, inj_done;
    int guard;
    inj_done = 1'b0;
    guard    = 0;
    cycle(1'b1, b, t8, md, next_tick(period));
    while (m_busy && guard < 20000) begin
      guard++;
      tk = next_tick(period);
      s  = 1'b0;
      if (noise && $urandom_range(0, 31) == 0) s = 1'b1;
      if (inject >= 0 && !inj_done && m_ticks == inject) begin
        s = 1'b1;
        inj_done = 1'b1;
      end
      if (edge_start && tk && (m_ticks + 1 == m_nbits * OS)) s = 1'b1;
      cycle(s, 8'hFF, 1'($urandom), noise ? 2'($urandom) : md, tk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd",  32'(txd),  32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ti",   32'(ti),   32'd0);
    rst_n = 1'b1;
    idle(4, 4);

    // Mode 1, 0xA5, tick every 4 clocks
    tick_ctr = 0; ti_count = 0;
    frame(8'hA5, 1'b0, 2'b01, 4, 1'b0, -1, 1'b0);
    check("m1_ti_once", 32'(ti_count), 32'd1);
    idle(5, 4);

    // Mode 2, 0x3C, TB8 = 1
    tick_ctr = 0; ti_count = 0;
    frame(8'h3C, 1'b1, 2'b10, 3, 1'b0, -1, 1'b0);
    check("m2_ti_once", 32'(ti_count), 32'd1);
    idle(3, 3);

    // Mode 1, 0x55 with an ignored 0xFF start during bit 4
    tick_ctr = 0; ti_count = 0;
    frame(8'h55, 1'b0, 2'b01, 2, 1'b0, 4 * OS + 3, 1'b0);
    check("ign_ti_once", 32'(ti_count), 32'd1);
    idle(3, 2);

    // Mode 3, 0x81 reset mid-DATA
    tick_ctr = 0; ti_count = 0;
    cycle(1'b1, 8'h81, 1'b1, 2'b11, next_tick(2));
    while (m_busy && m_ticks < 3 * OS + 5) cycle(1'b0, 8'h00, 1'b0, 2'b11, next_tick(2));
    #2 rst_n = 1'b0;
    #1;
    check("arst_txd",  32'(txd),  32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    m_busy = 1'b0; m_txd = 1'b1;
    idle(3, 2);
    @(negedge clk) rst_n = 1'b1;
    check("arst_no_ti", 32'(ti_count), 32'd0);
    tick_ctr = 0;
    frame(8'h12, 1'b0, 2'b01, 2, 1'b0, -1, 1'b0);
    idle(2, 2);

    // Mode 0 start is ignored
    ti_count = 0;
    cycle(1'b1, 8'h77, 1'b0, 2'b00, 1'b1);
    idle(40, 2);
    check("m0_no_ti", 32'(ti_count), 32'd0);

    // Start on the busy-fall clock is ignored, one clock later accepted
    tick_ctr = 0;
    frame(8'hC3, 1'b0, 2'b01, 2, 1'b0, -1, 1'b1);
    check("edge_idle", 32'(busy), 32'd0);
    frame(8'h5A, 1'b1, 2'b11, 2, 1'b0, -1, 1'b0);
    idle(3, 2);

    // Random frames with mid-frame noise
    for (int k = 0; k < 12; k++) begin
      int p;
      p        = $urandom_range(1, 4);
      tick_ctr = $urandom_range(0, 3);
      ti_count = 0;
      frame(8'($urandom), 1'($urandom), 2'($urandom_range(1, 3)), p, 1'b1, -1, 1'b0);
      check("rnd_ti_once", 32'(ti_count), 32'd1);
      idle($urandom_range(0, 5), p);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
